// File: rtl/multi_ch_timer.sv
// multi_ch_timer: a shared programmable prescaler plus NUM_CH independent
// interval timer channels. Each channel counts prescaler ticks up to a
// latched period and then wraps (periodic) or parks on its terminal count
// (one-shot), pulsing an expiry flag for one clock on every wrap.

module multi_ch_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [PRE_W-1:0]          i_prescale,
  input  logic                      i_presc_clr,
  input  logic [NUM_CH-1:0]         i_ch_start,
  input  logic [NUM_CH-1:0]         i_ch_stop,
  input  logic [NUM_CH-1:0]         i_ch_clr,
  input  logic [NUM_CH-1:0]         i_ch_oneshot,
  input  logic [NUM_CH*CNT_W-1:0]   i_ch_period,
  output logic                      o_tick,
  output logic [NUM_CH*CNT_W-1:0]   o_ch_count,
  output logic [NUM_CH-1:0]         o_ch_run,
  output logic [NUM_CH-1:0]         o_ch_expire
);

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  // ---------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] pcnt;
  logic             tick;

  // Tick on reaching the programmed limit; >= means a lowered limit below
  // the current count wraps at once instead of running up to all-ones.
  always_comb begin
    tick = !i_presc_clr && (pcnt >= i_prescale);
  end

  // Prescaler counter: cleared by the sync clear or by its own tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pcnt <= '0;
    end else if (i_presc_clr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Delayed copy of the tick, exported only for observation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tick <= 1'b0;
    end else begin
      o_tick <= tick;
    end
  end

  // ---------------------------------------------------------------------
  // Timer channels
  // ---------------------------------------------------------------------
  wire [NUM_CH*CNT_W-1:0] count_flat;
  wire [NUM_CH-1:0]       run_flat;
  wire [NUM_CH-1:0]       expire_flat;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             os_q, os_d;
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] period_in;

    assign period_in = i_ch_period[k*CNT_W +: CNT_W];

    // Channel next-state: clr beats start beats stop beats tick; the
    // expiry flag defaults low so it can only ever be a one-cycle pulse.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      per_d   = per_q;
      os_d    = os_q;
      exp_d   = 1'b0;
      if (i_ch_clr[k]) begin
        state_d = CH_IDLE;
        count_d = '0;
      end else if (i_ch_start[k]) begin
        state_d = CH_RUN;
        count_d = '0;
        per_d   = period_in;
        os_d    = i_ch_oneshot[k];
      end else if (i_ch_stop[k]) begin
        if (state_q != CH_IDLE) begin
          state_d = CH_IDLE;
        end
      end else if (tick && (state_q == CH_RUN)) begin
        if (count_q == per_q) begin
          exp_d = 1'b1;
          if (os_q) begin
            state_d = CH_DONE;
            count_d = per_q;
          end else begin
            count_d = '0;
            per_d   = period_in;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end

    // Channel registers, all updated on the same edge as the expiry pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= CH_IDLE;
        count_q <= '0;
        per_q   <= '0;
        os_q    <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        per_q   <= per_d;
        os_q    <= os_d;
        exp_q   <= exp_d;
      end
    end

    assign count_flat[k*CNT_W +: CNT_W] = count_q;
    assign run_flat[k]                  = (state_q == CH_RUN);
    assign expire_flat[k]               = exp_q;
  end

  // Gather per-channel results onto the packed output buses.
  always_comb begin
    o_ch_count  = count_flat;
    o_ch_run    = run_flat;
    o_ch_expire = expire_flat;
  end

endmodule

// File: tb/tb_multi_ch_timer.sv
// Testbench for multi_ch_timer: expected expiry cycles are queued per channel
// when stimulus is applied and matched against o_ch_expire pulses as they occur.

module tb_multi_ch_timer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int PRE_W  = 4;

  logic                    clk;
  logic                    rst;
  logic [PRE_W-1:0]        prescale;
  logic                    prescClr;
  logic [NUM_CH-1:0]       chStart;
  logic [NUM_CH-1:0]       chStop;
  logic [NUM_CH-1:0]       chClr;
  logic [NUM_CH-1:0]       chOneshot;
  logic [NUM_CH*CNT_W-1:0] chPeriod;
  logic                    dutTick;
  logic [NUM_CH*CNT_W-1:0] dutCount;
  logic [NUM_CH-1:0]       dutRun;
  logic [NUM_CH-1:0]       dutExpire;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;
  int expQ0[$];
  int expQ1[$];
  int expCyc0;
  int expCyc1;

  logic [CNT_W-1:0] countCh0;
  logic [CNT_W-1:0] countCh1;
  assign countCh0 = dutCount[CNT_W-1:0];
  assign countCh1 = dutCount[2*CNT_W-1:CNT_W];

  multi_ch_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_prescale   (prescale),
    .i_presc_clr  (prescClr),
    .i_ch_start   (chStart),
    .i_ch_stop    (chStop),
    .i_ch_clr     (chClr),
    .i_ch_oneshot (chOneshot),
    .i_ch_period  (chPeriod),
    .o_tick       (dutTick),
    .o_ch_count   (dutCount),
    .o_ch_run     (dutRun),
    .o_ch_expire  (dutExpire)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc is the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One-cycle pulse on the control inputs; returns the rising edge that sampled it.
  task automatic applyStimulus(input logic [NUM_CH-1:0] startV, input logic [NUM_CH-1:0] stopV,
                               input logic [NUM_CH-1:0] clrV, input logic prescClrV,
                               output int edgeNum);
    chStart  = startV;
    chStop   = stopV;
    chClr    = clrV;
    prescClr = prescClrV;
    @(negedge clk);
    edgeNum  = cyc;
    chStart  = '0;
    chStop   = '0;
    chClr    = '0;
    prescClr = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard: every expiry pulse must match the head of its channel queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (dutExpire[0]) begin
        if (expQ0.size() == 0) begin
          checkOutput("ch0_extra_expire", {31'd0, dutExpire[0]}, 32'd0);
        end else begin
          expCyc0 = expQ0.pop_front();
          checkOutput("ch0_expire_cycle", cyc, expCyc0);
        end
      end
      if (dutExpire[1]) begin
        if (expQ1.size() == 0) begin
          checkOutput("ch1_extra_expire", {31'd0, dutExpire[1]}, 32'd0);
        end else begin
          expCyc1 = expQ1.pop_front();
          checkOutput("ch1_expire_cycle", cyc, expCyc1);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int e;
    rst       = 1'b1;
    prescale  = '0;
    prescClr  = 1'b0;
    chStart   = '0;
    chStop    = '0;
    chClr     = '0;
    chOneshot = '0;
    chPeriod  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_count",  dutCount,  0);
    checkOutput("rst_run",    dutRun,    0);
    checkOutput("rst_expire", dutExpire, 0);
    checkOutput("rst_tick",   dutTick,   0);
    rst = 1'b0;
    @(negedge clk);

    // Periodic ch0, period 4, prescale 3: expire every 20 clocks
    $display("[TB] periodic prescaled channel");
    prescale      = 4'd3;
    chPeriod[7:0] = 8'd4;
    chOneshot     = 2'b00;
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1, s);
    expQ0.push_back(s + 20);
    expQ0.push_back(s + 40);
    expQ0.push_back(s + 60);
    waitUntil(s + 2);
    checkOutput("p_count0", countCh0, 0);
    waitUntil(s + 4);
    checkOutput("p_tick_hi", dutTick, 1);
    waitUntil(s + 5);
    checkOutput("p_tick_lo", dutTick, 0);
    for (int i = 1; i < 6; i++) begin
      waitUntil(s + 2 + 4 * i);
      checkOutput("p_count_step", countCh0, i % 5);
      checkOutput("p_run0", dutRun[0], 1);
    end
    waitUntil(s + 61);
    applyStimulus(2'b01 & 2'b00, 2'b01, 2'b00, 1'b0, e);
    checkOutput("p_stop_run0", dutRun[0], 0);
    checkOutput("p_stop_count0", countCh0, 0);
    waitUntil(e + 6);
    checkOutput("p_q0_empty", expQ0.size(), 0);

    // One-shot ch1, period 2, prescale 0
    $display("[TB] one-shot channel");
    prescale        = 4'd0;
    chPeriod[15:8]  = 8'd2;
    chOneshot       = 2'b10;
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b0, s);
    expQ1.push_back(s + 3);
    waitUntil(s + 1);
    checkOutput("os_count1_a", countCh1, 1);
    checkOutput("os_run1_a", dutRun[1], 1);
    waitUntil(s + 5);
    checkOutput("os_done_run1", dutRun[1], 0);
    checkOutput("os_hold_count1", countCh1, 2);
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b0, s);
    expQ1.push_back(s + 3);
    checkOutput("os_restart_count1", countCh1, 0);
    checkOutput("os_restart_run1", dutRun[1], 1);
    waitUntil(s + 1);
    checkOutput("os_restart_step", countCh1, 1);
    waitUntil(s + 6);
    checkOutput("os_q1_empty", expQ1.size(), 0);

    // Period 0 periodic on ch0: expire every cycle until stopped
    $display("[TB] period zero");
    chPeriod[7:0] = 8'd0;
    chOneshot     = 2'b00;
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b0, s);
    for (int i = 1; i <= 7; i++) expQ0.push_back(s + i);
    waitUntil(s + 3);
    checkOutput("z_count0", countCh0, 0);
    checkOutput("z_expire0", dutExpire[0], 1);
    waitUntil(s + 7);
    applyStimulus(2'b00, 2'b01, 2'b00, 1'b0, e);
    checkOutput("z_stop_run0", dutRun[0], 0);
    checkOutput("z_stop_expire0", dutExpire[0], 0);
    waitUntil(e + 3);
    checkOutput("z_hold_count0", countCh0, 0);
    checkOutput("z_q0_empty", expQ0.size(), 0);

    // Priority: clr+start and start+stop on ch0 while ch1 runs
    $display("[TB] control priority");
    chPeriod[7:0]  = 8'd3;
    chPeriod[15:8] = 8'd5;
    applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, s);
    expQ1.push_back(s + 6);
    expQ1.push_back(s + 12);
    expQ1.push_back(s + 18);
    waitUntil(s + 1);
    applyStimulus(2'b01, 2'b00, 2'b01, 1'b0, e);
    waitUntil(s + 3);
    checkOutput("pr_clr_run0", dutRun[0], 0);
    checkOutput("pr_clr_count0", countCh0, 0);
    checkOutput("pr_ch1_count", countCh1, 3);
    checkOutput("pr_ch1_run", dutRun[1], 1);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, e);
    for (int i = 1; i <= 4; i++) expQ0.push_back(e + 4 * i);
    checkOutput("pr_ss_run0", dutRun[0], 1);
    checkOutput("pr_ss_count0", countCh0, 0);
    waitUntil(e + 1);
    checkOutput("pr_ss_step0", countCh0, 1);
    waitUntil(s + 20);
    applyStimulus(2'b00, 2'b11, 2'b00, 1'b0, e);
    checkOutput("pr_stop_run", dutRun, 0);
    waitUntil(e + 3);
    checkOutput("pr_q0_empty", expQ0.size(), 0);
    checkOutput("pr_q1_empty", expQ1.size(), 0);

    // Period change mid-run takes effect at the next wrap
    $display("[TB] period change");
    chPeriod[7:0] = 8'd4;
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1, s);
    expQ0.push_back(s + 5);
    waitUntil(s + 2);
    chPeriod[7:0] = 8'd2;
    expQ0.push_back(s + 8);
    expQ0.push_back(s + 11);
    waitUntil(s + 4);
    checkOutput("pc_reach4", countCh0, 4);
    waitUntil(s + 6);
    checkOutput("pc_after_wrap", countCh0, 1);
    waitUntil(s + 11);
    applyStimulus(2'b00, 2'b01, 2'b00, 1'b0, e);
    waitUntil(e + 3);
    checkOutput("pc_q0_empty", expQ0.size(), 0);

    // Lowering the prescale below pcnt forces an immediate tick
    $display("[TB] prescale drop");
    prescale = 4'd15;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, s);
    waitUntil(s + 10);
    checkOutput("ps_no_tick", dutTick, 0);
    prescale = 4'd1;
    waitUntil(s + 11);
    checkOutput("ps_forced_tick", dutTick, 1);
    waitUntil(s + 12);
    checkOutput("ps_gap", dutTick, 0);
    waitUntil(s + 13);
    checkOutput("ps_tick2", dutTick, 1);
    waitUntil(s + 14);
    checkOutput("ps_gap2", dutTick, 0);
    waitUntil(s + 15);
    checkOutput("ps_tick3", dutTick, 1);

    // Asynchronous reset between edges
    $display("[TB] async reset");
    prescale      = 4'd0;
    chPeriod[7:0] = 8'd6;
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b0, s);
    waitUntil(s + 3);
    checkOutput("ar_pre_count0", countCh0, 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_count", dutCount, 0);
    checkOutput("ar_run", dutRun, 0);
    checkOutput("ar_expire", dutExpire, 0);
    checkOutput("ar_tick", dutTick, 0);
    @(negedge clk);
    rst = 1'b0;
    e = cyc;
    waitUntil(e + 20);
    checkOutput("ar_post_run", dutRun, 0);
    checkOutput("ar_post_count", dutCount, 0);
    checkOutput("ar_q0_empty", expQ0.size(), 0);
    checkOutput("ar_q1_empty", expQ1.size(), 0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/multi_ch_timer.md
Name: multi_ch_timer

Overview:
- Multi-channel, prescaled interval timer; the parametrised successor to the single-channel cycle/wrap counter.
- One shared runtime-programmable prescaler produces a tick.
- NUM_CH independent channels count ticks up to a per-channel period, each in periodic or one-shot mode, with start/stop/clear controls and expiry pulses.
- Sits beside control/sequencing logic as the common timebase for sampling windows, timeouts and periodic triggers.

Parameters:
- NUM_CH, 2, number of independent timer channels (>=1).
- CNT_W, 32, width of each channel counter and period value.
- PRE_W, 16, width of the prescaler counter and i_prescale.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_prescale  in  PRE_W  tick period minus one: one tick every i_prescale+1 clocks.
- i_presc_clr  in  1  synchronous clear of the prescaler counter.
- i_ch_start  in  NUM_CH  per-channel start/restart pulse.
- i_ch_stop  in  NUM_CH  per-channel stop pulse.
- i_ch_clr  in  NUM_CH  per-channel synchronous clear.
- i_ch_oneshot  in  NUM_CH  mode bit: 1 = one-shot, 0 = periodic; sampled at start.
- i_ch_period  in  NUM_CH*CNT_W  terminal count per channel; channel k occupies bits [k*CNT_W +: CNT_W].
- o_tick  out  1  registered copy of the internal prescaler tick.
- o_ch_count  out  NUM_CH*CNT_W  current count per channel, same packing as i_ch_period.
- o_ch_run  out  NUM_CH  1 while the channel is in RUN.
- o_ch_expire  out  NUM_CH  one-cycle pulse on each terminal-count wrap.

Behaviour:
- Reset (i_rst high, asynchronous): all registers and outputs go to 0, all channels go to IDLE, and the prescaler counter (pcnt) goes to 0.
- Prescaler:
  - tick = (pcnt >= i_prescale), combinational.
  - On tick, pcnt <= 0; otherwise pcnt <= pcnt+1.
  - i_prescale = 0 gives a tick every cycle.
  - The >= compare means lowering i_prescale below the current pcnt forces one tick and a wrap on the next edge, so there is no long runaway.
  - i_presc_clr: pcnt <= 0 and no tick that cycle. It has priority over the tick.
  - o_tick <= tick, one cycle late, for observation only.
- Channel state per channel: IDLE, RUN, DONE, plus shadow registers per_q (CNT_W) and os_q (1 bit).
- Priority per channel, per cycle: clr > start > stop > tick.
  - clr: state <= IDLE, count <= 0, expire <= 0.
  - start (any state, including RUN): state <= RUN, count <= 0, per_q <= i_ch_period slice, os_q <= i_ch_oneshot bit. A tick in the same cycle is ignored.
  - stop: RUN or DONE -> IDLE, count holds. Stop in IDLE has no effect.
  - tick while in RUN:
    - If count == per_q: count <= 0 and expire <= 1. If os_q, state <= DONE and count <= per_q (holds terminal value); otherwise stay RUN and reload per_q <= i_ch_period slice.
    - Otherwise count <= count+1.
  - IDLE and DONE ignore ticks; count holds.
- Latency and period rules:
  - Period P with prescale N: first expiry (P+1)*(N+1) ticks-worth of clocks after the start edge, assuming pcnt was 0 at start; then every (P+1)*(N+1) clocks thereafter.
  - Period changes take effect only at the next wrap in periodic mode, or at the next start.
  - Period 0 expires on every tick.
  - The counter never exceeds per_q, so it cannot overflow CNT_W.
- o_ch_expire is high for exactly one cycle per wrap, deasserts the following cycle, and is registered on the same edge as the count update.
- o_ch_run = (state == RUN).
- Channels are fully independent and share only the tick. Simultaneous events on different channels do not interact.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.

Test Plan:
- NUM_CH=2, CNT_W=8, PRE_W=4; i_prescale=3, ch0 period=4, periodic, start pulse -> o_ch_expire[0] pulses every 20 clocks; o_ch_count[0] steps 0,1,2,3,4,0 every 4 clocks; o_ch_run[0]=1 throughout.
- i_prescale=0, ch1 period=2, one-shot, start -> single expire pulse 3 clocks after start; then o_ch_run[1]=0 and o_ch_count[1] holds 2; a later start restarts from 0.
- i_prescale=0, period=0, periodic -> o_ch_expire high every cycle; then stop -> expire stops and count holds 0.
- Simultaneous clr+start on ch0 while running -> ch0 goes IDLE with count 0 (clr wins). Start+stop in the same cycle -> RUN with count 0. Meanwhile ch1 is unaffected.
- Change ch0 period 4->2 mid-run (periodic) -> current cycle still reaches 4 and expires, then the next expiry occurs at count 2. Drop i_prescale 15->1 while pcnt=10 -> tick on the next edge, then every 2 clocks.
- Assert i_rst asynchronously mid-count (between edges) -> all outputs 0 immediately; after release, no expiry occurs without a new start.
